// File: rtl/alu_if.sv
// alu_if: request/result bundle between the ALU sequencer and its driver.
interface alu_if #(parameter int WIDTH = 8);
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op_sel;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             neg;
  logic [2:0]       op_cur;
  logic             tick;
  modport master (
    output mode, a, b, op_sel, in_valid, out_ready,
    input  in_ready, out_valid, result, carry, zero, neg, op_cur, tick
  );
  modport slave (
    input  mode, a, b, op_sel, in_valid, out_ready,
    output in_ready, out_valid, result, carry, zero, neg, op_cur, tick
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: registered ALU with a manual valid/ready mode and an auto-stepping demo mode.
// Define ALU_MUL_EN to make op 7 a WIDTH x WIDTH multiply; otherwise op 7 yields 0.
module alu_sequencer #(
  parameter int WIDTH        = 8,
  parameter int TICK_DIV     = 100_000_000,
  parameter int LAST_AUTO_OP = 5
) (
  input logic  clk,
  input logic  rst_n,
  alu_if.slave bus
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic             mode_q, ov, tk, cy, zf, nf;
  logic [CW-1:0]    cnt;
  logic [2:0]       op_q, op_n;
  logic [WIDTH-1:0] res, res_n;
  logic             cy_n, sw, acc, last;

  // Returns {carry, result}; shifts use an extra bit so the last bit shifted out falls into carry.
  function automatic logic [WIDTH:0] alu(input logic [2:0] op, input logic [WIDTH-1:0] x,
                                         input logic [WIDTH-1:0] y);
    logic [WIDTH:0] t;
`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] p;
    p = {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};
`endif
    t = {x, 1'b0} >> y[SW-1:0];
    case (op)
      3'd0: return {1'b0, x} + {1'b0, y};
      3'd1: return {1'b0, x} - {1'b0, y};
      3'd2: return {1'b0, x & y};
      3'd3: return {1'b0, x | y};
      3'd4: return {1'b0, x} << y[SW-1:0];
      3'd5: return {t[0], t[WIDTH:1]};
      3'd6: return {1'b0, x ^ y};
`ifdef ALU_MUL_EN
      3'd7: return {|p[2*WIDTH-1:WIDTH], p[WIDTH-1:0]};
`endif
      default: return '0;
    endcase
  endfunction

  assign sw           = bus.mode != mode_q;
  assign last         = cnt == CW'(TICK_DIV - 1);
  assign bus.in_ready = rst_n && !bus.mode && !sw && (!ov || bus.out_ready);
  assign acc          = bus.in_valid && bus.in_ready;
  assign op_n         = bus.mode ? op_q : bus.op_sel;
  assign {cy_n, res_n} = alu(op_n, bus.a, bus.b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
      cnt    <= '0;
      op_q   <= '0;
      ov     <= 1'b0;
      tk     <= 1'b0;
      {cy, res, zf, nf} <= '0;
    end else begin
      mode_q <= bus.mode;
      if (sw) begin
        cnt  <= '0;
        op_q <= '0;
        ov   <= 1'b0;
        tk   <= 1'b0;
      end else if (bus.mode) begin
        cnt  <= last ? '0 : cnt + 1'b1;
        op_q <= !last ? op_q : op_q == 3'(LAST_AUTO_OP) ? 3'd0 : op_q + 3'd1;
        tk   <= last;
        ov   <= 1'b1;
        {cy, res, zf, nf} <= {cy_n, res_n, res_n == '0, res_n[WIDTH-1]};
      end else begin
        tk <= 1'b0;
        if (acc) begin
          op_q <= bus.op_sel;
          ov   <= 1'b1;
          {cy, res, zf, nf} <= {cy_n, res_n, res_n == '0, res_n[WIDTH-1]};
        end else if (bus.out_ready) begin
          ov <= 1'b0;
        end
      end
    end
  end

  assign bus.out_valid = ov;
  assign bus.result    = res;
  assign bus.carry     = cy;
  assign bus.zero      = zf;
  assign bus.neg       = nf;
  assign bus.op_cur    = op_q;
  assign bus.tick      = tk;
endmodule
